fifo_srl_af_ctrl: RTL

FIFO_SRL_AF_CTRL -- requirements
Module: fifo_srl_af_ctrl

---
 rtl/fifo_srl_af_ctrl_pkg.sv | 15 +
 rtl/fifo_srl_af_storage.sv | 41 ++++
 rtl/fifo_srl_af_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/fifo_srl_af_ctrl_pkg.sv
// Shared constants and helpers for the SRL-based almost-full FIFO.
//   count_width  : width of the SRL occupancy counter (one bit wider than the tap address)
//   af_threshold : occupancy at or above which the almost-full flag (if_full_n low) asserts
package fifo_srl_af_ctrl_pkg;

    function automatic int unsigned count_width(input int unsigned addr_width);
        return addr_width + 1;
    endfunction

    function automatic int unsigned af_threshold(input int unsigned depth,
                                                 input int unsigned grace);
        return depth - grace;
    endfunction

endpackage

// File: rtl/fifo_srl_af_storage.sv
// DEPTH x DATA_WIDTH shift-register storage with a tapped combinational read.
//   clk  : clock
//   data : word shifted into entry 0 when ce is high
//   ce   : shift enable
//   a    : tap address; q = entry a (entry 0 is the newest word)
//   q    : combinational tap output
// No reset: contents are only ever observed through the controller's occupancy count.
module fifo_srl_af_storage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  ce,
    input  logic [ADDR_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (ce) begin
            sr[0] <= data;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    // Explicit compare loop so taps beyond DEPTH (when DEPTH < 2^ADDR_WIDTH) read as zero.
    always_comb begin
        q = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a == ADDR_WIDTH'(i)) begin
                q = sr[i];
            end
        end
    end

endmodule

// File: rtl/fifo_srl_af_ctrl.sv
// First-word-fall-through FIFO built from a shift-register store plus a registered output word.
// Capacity is DEPTH+1 words. if_full_n drops early, leaving GRACE_PERIOD entries of headroom,
// but writes are still accepted until the SRL is truly full; a write beyond that is dropped
// and sets the sticky overflow flag.
//   clk, reset  : clock, asynchronous active-high reset
//   if_write_ce, if_write, if_din : write side
//   if_full_n   : almost-full, active low (registered)
//   if_read_ce, if_read           : read side, if_read pops the head word
//   if_dout, if_empty_n           : registered head word and its valid flag
//   overflow    : sticky dropped-write flag
module fifo_srl_af_ctrl
    import fifo_srl_af_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned GRACE_PERIOD = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic                  overflow
);

    localparam int unsigned CNT_W = count_width(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(af_threshold(DEPTH, GRACE_PERIOD));

    logic [CNT_W-1:0]      srl_count_q, srl_count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  empty_n_q, empty_n_d;
    logic                  full_n_q, full_n_d;
    logic                  overflow_q, overflow_d;

    logic                  wr_req;
    logic                  push;
    logic                  pop;
    logic                  load;
    logic [DATA_WIDTH-1:0] srl_q;

    fifo_srl_af_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk  (clk),
        .data (if_din),
        .ce   (push),
        .a    (addr_q),
        .q    (srl_q)
    );

    always_comb begin
        wr_req = if_write & if_write_ce;
        push   = wr_req & (srl_count_q < DEPTH_C);
        pop    = if_read & if_read_ce & empty_n_q;
        // Refill the output register whenever it is (or is about to become) empty.
        load   = (srl_count_q != '0) & (~empty_n_q | pop);

        srl_count_d = srl_count_q + CNT_W'(push) - CNT_W'(load);
        // Oldest SRL entry sits at index count-1 after this edge's shift.
        addr_d      = (srl_count_d == '0) ? '0 : ADDR_WIDTH'(srl_count_d - CNT_W'(1));
        dout_d      = load ? srl_q : dout_q;
        empty_n_d   = load | (empty_n_q & ~pop);
        full_n_d    = srl_count_d < THRESH_C;
        overflow_d  = overflow_q | (wr_req & (srl_count_q == DEPTH_C));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            srl_count_q <= '0;
            addr_q      <= '0;
            dout_q      <= '0;
            empty_n_q   <= 1'b0;
            full_n_q    <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            srl_count_q <= srl_count_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            empty_n_q   <= empty_n_d;
            full_n_q    <= full_n_d;
            overflow_q  <= overflow_d;
        end
    end

    assign if_dout    = dout_q;
    assign if_empty_n = empty_n_q;
    assign if_full_n  = full_n_q;
    assign overflow   = overflow_q;

endmodule
